// File: rtl/ste_edge_filt.sv
// Multi-channel input conditioner: synchroniser, counter-based glitch filter,
// per-channel edge select and sticky event flags with combined any_o.
module ste_edge_filt #(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYC     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CH-1:0]     din_i,
   input  logic [2*CH-1:0]   mode_i,
   input  logic [CH-1:0]     clr_i,
   output logic [CH-1:0]     level_o,
   output logic [CH-1:0]     edge_o,
   output logic [CH-1:0]     sticky_o,
   output logic              any_o
);

   localparam int CW = $clog2(DEB_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [CH-1:0] s;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = din_i;
      end else begin : g_sync
         logic [CH-1:0] sync_q [SYNC_STAGES];
         logic [CH-1:0] sync_d [SYNC_STAGES];

         always_comb begin
            sync_d[0] = din_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               sync_d[i] = sync_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
               if (rst) begin
                  sync_q[i] <= '0;
               end else begin
                  sync_q[i] <= sync_d[i];
               end
            end
         end

         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   logic [CH-1:0] lvl_q, lvl_d;
   logic [CH-1:0] edge_q, edge_d;
   logic [CH-1:0] sticky_q, sticky_d;
   logic [CW-1:0] cnt_q [CH];
   logic [CW-1:0] cnt_d [CH];

   // A new sample must persist DEB_CYC cycles; any return to lvl restarts the count.
   always_comb begin
      lvl_d    = lvl_q;
      edge_d   = '0;
      sticky_d = (sticky_q & ~clr_i) | edge_q;
      for (int c = 0; c < CH; c++) begin
         cnt_d[c] = cnt_q[c];
         if (s[c] == lvl_q[c]) begin
            cnt_d[c] = '0;
         end else if (cnt_q[c] == CNT_MAX) begin
            lvl_d[c]  = s[c];
            cnt_d[c]  = '0;
            edge_d[c] = s[c] ? mode_i[2*c] : mode_i[2*c+1];
         end else begin
            cnt_d[c] = cnt_q[c] + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_q    <= '0;
         edge_q   <= '0;
         sticky_q <= '0;
         for (int c = 0; c < CH; c++) begin
            cnt_q[c] <= '0;
         end
      end else begin
         lvl_q    <= lvl_d;
         edge_q   <= edge_d;
         sticky_q <= sticky_d;
         for (int c = 0; c < CH; c++) begin
            cnt_q[c] <= cnt_d[c];
         end
      end
   end

   assign level_o  = lvl_q;
   assign edge_o   = edge_q;
   assign sticky_o = sticky_q;
   assign any_o    = |sticky_q;

endmodule

// File: tb/tb_ste_edge_filt.sv
// Bench for ste_edge_filt: table-driven cycle vectors into a due-cycle scoreboard,
// plus hand sequences for sticky priority, reset mid-count and a parameter sweep.
module tb_ste_edge_filt;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] din, clr, level, edg, sticky;
   logic [7:0] mode;
   logic       any;

   logic [7:0]  din1, clr1, level1, edge1, sticky1;
   logic [15:0] mode1;
   logic        any1;
   logic [0:0]  din2, clr2, level2, edge2, sticky2;
   logic [1:0]  mode2;
   logic        any2;

   always #5 clk = ~clk;

   ste_edge_filt dut (
      .clk(clk), .rst(rst), .din_i(din), .mode_i(mode), .clr_i(clr),
      .level_o(level), .edge_o(edg), .sticky_o(sticky), .any_o(any)
   );

   ste_edge_filt #(.CH(8), .SYNC_STAGES(0), .DEB_CYC(1)) u_fast (
      .clk(clk), .rst(rst), .din_i(din1), .mode_i(mode1), .clr_i(clr1),
      .level_o(level1), .edge_o(edge1), .sticky_o(sticky1), .any_o(any1)
   );

   ste_edge_filt #(.CH(1), .SYNC_STAGES(3), .DEB_CYC(16)) u_slow (
      .clk(clk), .rst(rst), .din_i(din2), .mode_i(mode2), .clr_i(clr2),
      .level_o(level2), .edge_o(edge2), .sticky_o(sticky2), .any_o(any2)
   );

   typedef struct {
      int         due;
      logic [3:0] lvl;
      logic [3:0] edg;
      logic [3:0] stk;
      string      tag;
   } exp_t;

   typedef struct {
      logic       rst;
      logic [3:0] din;
      logic [7:0] mode;
      logic [3:0] clr;
      int         n;
      logic [3:0] lvl;
      logic [3:0] edg;
      logic [3:0] stk;
   } vec_t;

   exp_t sb[$];
   exp_t cur;
   vec_t tbl[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_chk = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   task automatic push_exp(int due, logic [3:0] l, logic [3:0] e, logic [3:0] s, string tag);
      exp_t x;
      int   i;
      x.due = due;
      x.lvl = l;
      x.edg = e;
      x.stk = s;
      x.tag = tag;
      i = 0;
      while (i < sb.size() && sb[i].due <= due) i++;
      sb.insert(i, x);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         cur = sb.pop_front();
         chk($sformatf("%s@%0d due", cur.tag, cur.due), cyc, cur.due);
         chk($sformatf("%s@%0d level", cur.tag, cur.due), level, cur.lvl);
         chk($sformatf("%s@%0d edge", cur.tag, cur.due), edg, cur.edg);
         chk($sformatf("%s@%0d sticky", cur.tag, cur.due), sticky, cur.stk);
         chk($sformatf("%s@%0d any", cur.tag, cur.due), any, |cur.stk);
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic vec_t mk(logic r, logic [3:0] d, logic [7:0] m, logic [3:0] c, int n,
                               logic [3:0] l, logic [3:0] e, logic [3:0] s);
      vec_t v;
      v.rst = r; v.din = d; v.mode = m; v.clr = c; v.n = n;
      v.lvl = l; v.edg = e; v.stk = s;
      return v;
   endfunction

   // ch1 toggles high 8 cycles then low 8; outputs lag the inputs by 5 rows.
   task automatic add_block(logic [7:0] m, logic [3:0] re, logic [3:0] fe,
                            logic [3:0] s0, logic [3:0] s1, logic [3:0] s2);
      tbl.push_back(mk(1'b0, 4'h2, m, 4'h0, 5, 4'h0, 4'h0, s0));
      tbl.push_back(mk(1'b0, 4'h2, m, 4'h0, 1, 4'h2, re,   s0));
      tbl.push_back(mk(1'b0, 4'h2, m, 4'h0, 2, 4'h2, 4'h0, s1));
      tbl.push_back(mk(1'b0, 4'h0, m, 4'h0, 5, 4'h2, 4'h0, s1));
      tbl.push_back(mk(1'b0, 4'h0, m, 4'h0, 1, 4'h0, fe,   s1));
      tbl.push_back(mk(1'b0, 4'h0, m, 4'h0, 2, 4'h0, 4'h0, s2));
   endtask

   task automatic do_reset();
      rst = 1'b1; din = 4'h0; clr = 4'h0;
      tick(2);
      rst = 1'b0;
      tick(2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, j, off;
      rst = 1'b1; din = 4'h0; mode = 8'h00; clr = 4'h0;
      din1 = '0; mode1 = 16'hFFFF; clr1 = '0;
      din2 = '0; mode2 = 2'b11; clr2 = '0;

      // reset with inputs high, then the rising edge after release
      tbl.push_back(mk(1'b1, 4'hF, 8'hFF, 4'h0, 3, 4'h0, 4'h0, 4'h0));
      tbl.push_back(mk(1'b0, 4'hF, 8'hFF, 4'h0, 5, 4'h0, 4'h0, 4'h0));
      tbl.push_back(mk(1'b0, 4'hF, 8'hFF, 4'h0, 1, 4'hF, 4'hF, 4'h0));
      tbl.push_back(mk(1'b0, 4'hF, 8'hFF, 4'h0, 2, 4'hF, 4'h0, 4'hF));
      // glitch filter on ch0, rising only
      tbl.push_back(mk(1'b1, 4'h0, 8'h01, 4'h0, 2, 4'h0, 4'h0, 4'h0));
      tbl.push_back(mk(1'b0, 4'h0, 8'h01, 4'h0, 2, 4'h0, 4'h0, 4'h0));
      tbl.push_back(mk(1'b0, 4'h1, 8'h01, 4'h0, 3, 4'h0, 4'h0, 4'h0));
      tbl.push_back(mk(1'b0, 4'h0, 8'h01, 4'h0, 10, 4'h0, 4'h0, 4'h0));
      tbl.push_back(mk(1'b0, 4'h1, 8'h01, 4'h0, 4, 4'h0, 4'h0, 4'h0));
      tbl.push_back(mk(1'b0, 4'h0, 8'h01, 4'h0, 1, 4'h0, 4'h0, 4'h0));
      tbl.push_back(mk(1'b0, 4'h0, 8'h01, 4'h0, 1, 4'h1, 4'h1, 4'h0));
      tbl.push_back(mk(1'b0, 4'h0, 8'h01, 4'h0, 3, 4'h1, 4'h0, 4'h1));
      tbl.push_back(mk(1'b0, 4'h0, 8'h01, 4'h0, 4, 4'h0, 4'h0, 4'h1));
      // mode select on ch1: off, rise, both, fall
      tbl.push_back(mk(1'b1, 4'h0, 8'h00, 4'h0, 2, 4'h0, 4'h0, 4'h0));
      tbl.push_back(mk(1'b0, 4'h0, 8'h00, 4'h0, 2, 4'h0, 4'h0, 4'h0));
      add_block(8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add_block(8'h04, 4'h2, 4'h0, 4'h0, 4'h2, 4'h2);
      add_block(8'h0C, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2);
      add_block(8'h08, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2);

      for (int r = 0; r < tbl.size(); r++) begin
         for (int c = 0; c < tbl[r].n; c++) begin
            rst = tbl[r].rst; din = tbl[r].din; mode = tbl[r].mode; clr = tbl[r].clr;
            push_exp(cyc + 1, tbl[r].lvl, tbl[r].edg, tbl[r].stk, $sformatf("row%0d", r));
            tick(1);
         end
      end

      // sticky: set, set-and-clear on the same edge, clear alone
      do_reset();
      mode = 8'h30;
      k = cyc;
      din = 4'h4;
      push_exp(k + 5, 4'h0, 4'h0, 4'h0, "stk_pre");
      push_exp(k + 6, 4'h4, 4'h4, 4'h0, "stk_edge");
      push_exp(k + 7, 4'h4, 4'h0, 4'h4, "stk_set");
      tick(8);
      j = cyc;
      din = 4'h0;
      push_exp(j + 6, 4'h0, 4'h4, 4'h4, "stk_edge2");
      tick(6);
      clr = 4'h4;
      push_exp(j + 7, 4'h0, 4'h0, 4'h4, "stk_set_wins");
      tick(1);
      clr = 4'h0;
      push_exp(j + 8, 4'h0, 4'h0, 4'h4, "stk_hold");
      tick(1);
      clr = 4'h4;
      push_exp(j + 9, 4'h0, 4'h0, 4'h0, "stk_clr");
      tick(1);
      clr = 4'h0;
      tick(2);

      // reset while ch3 counter sits at 2
      do_reset();
      mode = 8'hC0;
      k = cyc;
      din = 4'h8;
      tick(4);
      rst = 1'b1;
      push_exp(k + 5, 4'h0, 4'h0, 4'h0, "mid_rst");
      tick(1);
      rst = 1'b0;
      for (int i = 6; i <= 10; i++) push_exp(k + i, 4'h0, 4'h0, 4'h0, "mid_wait");
      push_exp(k + 11, 4'h8, 4'h8, 4'h0, "mid_edge");
      push_exp(k + 12, 4'h8, 4'h0, 4'h8, "mid_stk");
      tick(9);

      // parameter sweep: all channels rise together on both extra instances
      do_reset();
      k = cyc;
      din1 = 8'hFF;
      din2 = 1'b1;
      repeat (23) begin
         @(negedge clk);
         off = cyc - k;
         chk($sformatf("fast level off%0d", off), level1, (off >= 1) ? 8'hFF : 8'h00);
         chk($sformatf("fast edge off%0d", off), edge1, (off == 1) ? 8'hFF : 8'h00);
         chk($sformatf("fast sticky off%0d", off), sticky1, (off >= 2) ? 8'hFF : 8'h00);
         chk($sformatf("slow level off%0d", off), level2, (off >= 19) ? 1 : 0);
         chk($sformatf("slow edge off%0d", off), edge2, (off == 19) ? 1 : 0);
         chk($sformatf("slow any off%0d", off), any2, (off >= 20) ? 1 : 0);
      end
      chk("fast any", any1, 1);

      tick(3);
      chk("scoreboard drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
